// File: rtl/charram_seq_pkg.sv
// Shared constants for the char-RAM access sequencer: slot phase numbers,
// grant encoding and the row/column split of the 14-bit bank address.
package charram_seq_pkg;

    localparam int unsigned PH_ROW = 1;
    localparam int unsigned PH_COL = 2;
    localparam int unsigned PH_STB = 3;
    localparam int unsigned PH_CAP = 4;
    localparam int unsigned PH_RET = 5;

    localparam int unsigned ROW_MSB = 7;
    localparam int unsigned COL_LSB = 8;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_VID  = 2'd1,
        GNT_CPU  = 2'd2,
        GNT_REF  = 2'd3
    } gnt_e;

endpackage

// File: rtl/charram_refresh_ctr.sv
// 8-bit wrapping refresh row counter; only built when CHARRAM_REFRESH_EN is defined.
`ifdef CHARRAM_REFRESH_EN
module charram_refresh_ctr (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       inc_i,
    output logic [7:0] row_o
);

    logic [7:0] row_q;
    logic [7:0] row_d;

    // Advance by one per completed refresh, naturally wrapping 255 -> 0.
    always_comb begin
        row_d = row_q;
        if (inc_i) begin
            row_d = row_q + 8'd1;
        end else begin
            row_d = row_q;
        end
    end

    // Row register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            row_q <= 8'd0;
        end else begin
            row_q <= row_d;
        end
    end

    assign row_o = row_q;

endmodule
`endif

// File: rtl/charram_access_sequencer.sv
// Slot sequencer sharing one 4416 char-RAM bank between video fetch (priority) and CPU.
// Define CHARRAM_REFRESH_EN to run RAS-only refresh cycles in otherwise idle slots.
module charram_access_sequencer
    import charram_seq_pkg::*;
#(
    parameter int unsigned SLOT_LEN = 8,
    parameter int unsigned CNT_W    = 3
) (
    input  logic        i_MCLK,
    input  logic        i_RST,
    input  logic        i_SYNC,
    input  logic        i_VID_REQ,
    input  logic [13:0] i_VID_ADDR,
    output logic        o_VID_VALID,
    output logic [3:0]  o_VID_DATA,
    input  logic        i_CPU_REQ,
    input  logic        i_CPU_WE,
    input  logic [13:0] i_CPU_ADDR,
    input  logic [3:0]  i_CPU_DIN,
    output logic        o_CPU_ACK,
    output logic [3:0]  o_CPU_DOUT,
    output logic [7:0]  o_DRAM_ADDR,
    output logic        o_RAS_n,
    output logic        o_CAS_n,
    output logic        o_WR_n,
    output logic        o_RD_n,
    output logic [3:0]  o_DRAM_DIN,
    input  logic [3:0]  i_DRAM_DOUT
);

    localparam logic [CNT_W-1:0] P_IDLE = CNT_W'(0);
    localparam logic [CNT_W-1:0] P_ROW  = CNT_W'(PH_ROW);
    localparam logic [CNT_W-1:0] P_COL  = CNT_W'(PH_COL);
    localparam logic [CNT_W-1:0] P_STB  = CNT_W'(PH_STB);
    localparam logic [CNT_W-1:0] P_CAP  = CNT_W'(PH_CAP);
    localparam logic [CNT_W-1:0] P_RET  = CNT_W'(PH_RET);
    localparam logic [CNT_W-1:0] P_LAST = CNT_W'(SLOT_LEN - 1);

`ifdef CHARRAM_REFRESH_EN
    localparam gnt_e IDLE_GNT = GNT_REF;
    logic       ref_inc_s;
    logic [7:0] ref_row_s;

    charram_refresh_ctr u_refresh_ctr (
        .clk_i (i_MCLK),
        .rst_i (i_RST),
        .inc_i (ref_inc_s),
        .row_o (ref_row_s)
    );
`else
    localparam gnt_e IDLE_GNT = GNT_NONE;
`endif

    logic [CNT_W-1:0] phase_q, phase_d;
    gnt_e             grant_q, grant_d;
    logic [13:0]      addr_q, addr_d;
    logic             we_q, we_d;
    logic [3:0]       din_q, din_d;
    logic             abort_s;
    logic [7:0]       row_s, col_s;

    logic       ras_q, ras_d, cas_q, cas_d, wr_q, wr_d, rd_q, rd_d;
    logic [7:0] dram_addr_q, dram_addr_d;
    logic [3:0] dram_din_q, dram_din_d;
    logic       vid_valid_q, vid_valid_d, cpu_ack_q, cpu_ack_d;
    logic [3:0] vid_data_q, vid_data_d, cpu_dout_q, cpu_dout_d;

    // Phase counter and phase-0 arbitration; a realign inside an active access drops the grant.
    always_comb begin
        abort_s = i_SYNC && (grant_q != GNT_NONE) && (phase_q >= P_ROW) && (phase_q <= P_CAP);
        if (i_SYNC) begin
            phase_d = P_IDLE;
        end else if (phase_q == P_LAST) begin
            phase_d = P_IDLE;
        end else begin
            phase_d = phase_q + CNT_W'(1);
        end
        grant_d = grant_q;
        addr_d  = addr_q;
        we_d    = we_q;
        din_d   = din_q;
        if (phase_q == P_IDLE) begin
            if (i_VID_REQ) begin
                grant_d = GNT_VID;
                addr_d  = i_VID_ADDR;
                we_d    = 1'b0;
            end else if (i_CPU_REQ) begin
                grant_d = GNT_CPU;
                addr_d  = i_CPU_ADDR;
                we_d    = i_CPU_WE;
                din_d   = i_CPU_DIN;
            end else begin
                grant_d = IDLE_GNT;
            end
        end else if (abort_s) begin
            grant_d = GNT_NONE;
        end else begin
            grant_d = grant_q;
        end
    end

    // Output next-state from the upcoming phase and grant so every pin comes straight off a flop.
    always_comb begin
        ras_d       = 1'b1;
        cas_d       = 1'b1;
        wr_d        = 1'b1;
        rd_d        = 1'b1;
        dram_addr_d = dram_addr_q;
        dram_din_d  = dram_din_q;
        vid_valid_d = 1'b0;
        cpu_ack_d   = 1'b0;
        vid_data_d  = vid_data_q;
        cpu_dout_d  = cpu_dout_q;
`ifdef CHARRAM_REFRESH_EN
        ref_inc_s   = 1'b0;
`endif
        row_s = addr_d[ROW_MSB:0];
        col_s = {1'b0, addr_d[13:COL_LSB], 1'b0};
        case (grant_d)
            GNT_VID, GNT_CPU: begin
                case (phase_d)
                    P_IDLE: dram_addr_d = row_s;
                    P_ROW: begin
                        ras_d       = 1'b0;
                        dram_addr_d = row_s;
                    end
                    P_COL, P_CAP: begin
                        ras_d       = 1'b0;
                        cas_d       = 1'b0;
                        dram_addr_d = col_s;
                    end
                    P_STB: begin
                        ras_d       = 1'b0;
                        cas_d       = 1'b0;
                        dram_addr_d = col_s;
                        if (we_d) begin
                            wr_d       = 1'b0;
                            dram_din_d = din_d;
                        end else begin
                            rd_d = 1'b0;
                        end
                    end
                    P_RET: begin
                        // i_DRAM_DOUT is sampled on the edge that ends the capture phase.
                        if (grant_d == GNT_VID) begin
                            vid_valid_d = 1'b1;
                            vid_data_d  = i_DRAM_DOUT;
                        end else begin
                            cpu_ack_d = 1'b1;
                            if (!we_d) begin
                                cpu_dout_d = i_DRAM_DOUT;
                            end else begin
                                cpu_dout_d = cpu_dout_q;
                            end
                        end
                    end
                    default: ;
                endcase
            end
`ifdef CHARRAM_REFRESH_EN
            GNT_REF: begin
                case (phase_d)
                    P_ROW, P_COL, P_STB: begin
                        ras_d       = 1'b0;
                        dram_addr_d = ref_row_s;
                    end
                    P_RET:   ref_inc_s = 1'b1;
                    default: ;
                endcase
            end
`endif
            default: ;
        endcase
    end

    // Slot state: phase, grant and the latched winner's request.
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            phase_q <= P_IDLE;
            grant_q <= GNT_NONE;
            addr_q  <= 14'd0;
            we_q    <= 1'b0;
            din_q   <= 4'd0;
        end else begin
            phase_q <= phase_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            din_q   <= din_d;
        end
    end

    // Registered DRAM strobes and client-facing outputs.
    always_ff @(posedge i_MCLK or posedge i_RST) begin
        if (i_RST) begin
            ras_q       <= 1'b1;
            cas_q       <= 1'b1;
            wr_q        <= 1'b1;
            rd_q        <= 1'b1;
            dram_addr_q <= 8'd0;
            dram_din_q  <= 4'd0;
            vid_valid_q <= 1'b0;
            cpu_ack_q   <= 1'b0;
            vid_data_q  <= 4'd0;
            cpu_dout_q  <= 4'd0;
        end else begin
            ras_q       <= ras_d;
            cas_q       <= cas_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            dram_addr_q <= dram_addr_d;
            dram_din_q  <= dram_din_d;
            vid_valid_q <= vid_valid_d;
            cpu_ack_q   <= cpu_ack_d;
            vid_data_q  <= vid_data_d;
            cpu_dout_q  <= cpu_dout_d;
        end
    end

    assign o_RAS_n     = ras_q;
    assign o_CAS_n     = cas_q;
    assign o_WR_n      = wr_q;
    assign o_RD_n      = rd_q;
    assign o_DRAM_ADDR = dram_addr_q;
    assign o_DRAM_DIN  = dram_din_q;
    assign o_VID_VALID = vid_valid_q;
    assign o_VID_DATA  = vid_data_q;
    assign o_CPU_ACK   = cpu_ack_q;
    assign o_CPU_DOUT  = cpu_dout_q;

endmodule

// File: tb/tb_charram_access_sequencer.sv
// Directed bench for charram_access_sequencer with a small 4416 DRAM model.
module tb_charram_access_sequencer;

    logic        clk = 1'b0;
    logic        rst, sync, vid_req, cpu_req, cpu_we;
    logic [13:0] vid_addr, cpu_addr;
    logic [3:0]  cpu_din;
    logic        vid_valid, cpu_ack, ras_n, cas_n, wr_n, rd_n;
    logic [3:0]  vid_data, cpu_dout, dram_din;
    logic [3:0]  dram_dout = 4'd0;
    logic [7:0]  dram_addr;

    int checks = 0;
    int errors = 0;

    localparam logic [13:0] VTAB [4] = '{14'h0C40, 14'h1111, 14'h2222, 14'h3F0E};

    always #5 clk = ~clk;

    charram_access_sequencer dut (
        .i_MCLK(clk), .i_RST(rst), .i_SYNC(sync),
        .i_VID_REQ(vid_req), .i_VID_ADDR(vid_addr),
        .o_VID_VALID(vid_valid), .o_VID_DATA(vid_data),
        .i_CPU_REQ(cpu_req), .i_CPU_WE(cpu_we), .i_CPU_ADDR(cpu_addr), .i_CPU_DIN(cpu_din),
        .o_CPU_ACK(cpu_ack), .o_CPU_DOUT(cpu_dout),
        .o_DRAM_ADDR(dram_addr), .o_RAS_n(ras_n), .o_CAS_n(cas_n),
        .o_WR_n(wr_n), .o_RD_n(rd_n), .o_DRAM_DIN(dram_din), .i_DRAM_DOUT(dram_dout)
    );

    // Unwritten cells read back a fixed pattern of their address.
    function automatic logic [3:0] pat(input logic [13:0] a);
        return a[3:0] ^ a[13:10];
    endfunction

    logic [3:0]     mem [16384];
    logic [16383:0] wflag = '0;
    logic [7:0]     row_l = 8'd0;
    logic [5:0]     col_l = 6'd0;

    // DRAM model: row on RAS alone, column while CAS low, registered read data.
    always @(posedge clk) begin
        if (!ras_n && cas_n) row_l <= dram_addr;
        if (!cas_n) col_l <= dram_addr[6:1];
        if (!wr_n) begin
            mem[{col_l, row_l}]   <= dram_din;
            wflag[{col_l, row_l}] <= 1'b1;
        end
        if (!rd_n) dram_dout <= wflag[{col_l, row_l}] ? mem[{col_l, row_l}] : pat({col_l, row_l});
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic align();
        sync = 1'b1;
        step(1);
        sync = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sync = 1'b0; vid_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
        vid_addr = 14'd0; cpu_addr = 14'd0; cpu_din = 4'd0;
        step(2);
        checks++; if ({ras_n, cas_n, wr_n, rd_n} !== 4'hF) begin errors++; $display("FAIL rst_strobes got %b exp 1111", {ras_n, cas_n, wr_n, rd_n}); end
        checks++; if ({vid_valid, cpu_ack} !== 2'b00) begin errors++; $display("FAIL rst_pulses got %b exp 00", {vid_valid, cpu_ack}); end
        checks++; if ({dram_addr, dram_din, vid_data, cpu_dout} !== 20'h0) begin errors++; $display("FAIL rst_data got %h exp 0", {dram_addr, dram_din, vid_data, cpu_dout}); end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        align();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h02A5; cpu_din = 4'hC;
        step(1);
        checks++; if ({ras_n, cas_n, dram_addr} !== {1'b0, 1'b1, 8'hA5}) begin errors++; $display("FAIL wr_row got %h exp %h", {ras_n, cas_n, dram_addr}, {1'b0, 1'b1, 8'hA5}); end
        step(1);
        checks++; if ({ras_n, cas_n, dram_addr} !== {1'b0, 1'b0, 8'h04}) begin errors++; $display("FAIL wr_col got %h exp %h", {ras_n, cas_n, dram_addr}, {1'b0, 1'b0, 8'h04}); end
        step(1);
        checks++; if ({wr_n, rd_n, dram_din} !== {1'b0, 1'b1, 4'hC}) begin errors++; $display("FAIL wr_strobe got %h exp %h", {wr_n, rd_n, dram_din}, {1'b0, 1'b1, 4'hC}); end
        step(1);
        checks++; if ({wr_n, cpu_ack} !== 2'b10) begin errors++; $display("FAIL wr_ph4 got %b exp 10", {wr_n, cpu_ack}); end
        step(1);
        checks++; if ({cpu_ack, ras_n, cas_n, cpu_dout} !== {3'b111, 4'h0}) begin errors++; $display("FAIL wr_ack got %h exp %h", {cpu_ack, ras_n, cas_n, cpu_dout}, {3'b111, 4'h0}); end
        cpu_req = 1'b0;
        step(1);
        checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL wr_ack_pulse got %b exp 0", cpu_ack); end
        step(2);
        cpu_req = 1'b1; cpu_we = 1'b0;
        step(3);
        checks++; if ({rd_n, wr_n} !== 2'b01) begin errors++; $display("FAIL rd_strobe got %b exp 01", {rd_n, wr_n}); end
        step(2);
        checks++; if ({cpu_ack, cpu_dout} !== {1'b1, 4'hC}) begin errors++; $display("FAIL rd_ack got %h exp %h", {cpu_ack, cpu_dout}, {1'b1, 4'hC}); end
        cpu_req = 1'b0;
        step(3);
    endtask

    task automatic test_contention();
        int cyc;
        bit got;
        align();
        vid_req = 1'b1; vid_addr = 14'h0B17;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h1E4C;
        step(1);
        vid_req = 1'b0;
        step(3);
        checks++; if (vid_valid !== 1'b0) begin errors++; $display("FAIL ct_valid_early got %b exp 0", vid_valid); end
        step(1);
        checks++; if ({vid_valid, cpu_ack, vid_data} !== {2'b10, pat(14'h0B17)}) begin errors++; $display("FAIL ct_valid got %h exp %h", {vid_valid, cpu_ack, vid_data}, {2'b10, pat(14'h0B17)}); end
        cyc = 5; got = 1'b0;
        while (!got && cyc < 30) begin
            step(1); cyc++;
            if (cpu_ack) got = 1'b1;
        end
        checks++; if (cyc != 13) begin errors++; $display("FAIL ct_ack_latency got %0d exp 13", cyc); end
        checks++; if (cpu_dout !== pat(14'h1E4C)) begin errors++; $display("FAIL ct_dout got %h exp %h", cpu_dout, pat(14'h1E4C)); end
        cpu_req = 1'b0;
        step(3);
    endtask

    task automatic test_back_to_back();
        int early_acks;
        int stray_valids;
        align();
        early_acks = 0; stray_valids = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h3A61;
        for (int s = 0; s < 5; s++) begin
            vid_req = (s < 4);
            vid_addr = VTAB[s % 4];
            for (int p = 1; p <= 8; p++) begin
                step(1);
                if (p == 1) vid_req = 1'b0;
                if (s < 4) begin
                    if (cpu_ack) early_acks++;
                    if (p == 5) begin
                        checks++; if ({vid_valid, vid_data} !== {1'b1, pat(VTAB[s])}) begin errors++; $display("FAIL b2b_valid slot %0d got %h exp %h", s, {vid_valid, vid_data}, {1'b1, pat(VTAB[s])}); end
                    end else if (vid_valid) begin
                        stray_valids++;
                    end
                end else if (p == 5) begin
                    checks++; if ({cpu_ack, cpu_dout} !== {1'b1, pat(14'h3A61)}) begin errors++; $display("FAIL b2b_cpu_ack got %h exp %h", {cpu_ack, cpu_dout}, {1'b1, pat(14'h3A61)}); end
                    cpu_req = 1'b0;
                end
            end
        end
        checks++; if (early_acks != 0) begin errors++; $display("FAIL b2b_early_ack got %0d exp 0", early_acks); end
        checks++; if (stray_valids != 0) begin errors++; $display("FAIL b2b_stray_valid got %0d exp 0", stray_valids); end
    endtask

    task automatic test_sync_abort();
        int cyc;
        bit got;
        align();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0D3B;
        step(2);
        checks++; if (cas_n !== 1'b0) begin errors++; $display("FAIL sy_cas got %b exp 0", cas_n); end
        sync = 1'b1;
        step(1);
        sync = 1'b0;
        checks++; if ({ras_n, cas_n, rd_n, cpu_ack} !== 4'b1110) begin errors++; $display("FAIL sy_abort got %b exp 1110", {ras_n, cas_n, rd_n, cpu_ack}); end
        cyc = 0; got = 1'b0;
        while (!got && cyc < 20) begin
            step(1); cyc++;
            if (cpu_ack) got = 1'b1;
        end
        checks++; if (cyc != 5) begin errors++; $display("FAIL sy_regrant_latency got %0d exp 5", cyc); end
        checks++; if (cpu_dout !== pat(14'h0D3B)) begin errors++; $display("FAIL sy_dout got %h exp %h", cpu_dout, pat(14'h0D3B)); end
        cpu_req = 1'b0;
        step(3);
    endtask

    task automatic test_reset_mid();
        int cyc;
        bit got;
        align();
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h0155; cpu_din = 4'h5;
        step(3);
        checks++; if (wr_n !== 1'b0) begin errors++; $display("FAIL rm_wr got %b exp 0", wr_n); end
        rst = 1'b1;
        #1;
        checks++; if ({ras_n, cas_n, wr_n, rd_n, cpu_ack} !== 5'b11110) begin errors++; $display("FAIL rm_async got %b exp 11110", {ras_n, cas_n, wr_n, rd_n, cpu_ack}); end
        cpu_req = 1'b0; cpu_we = 1'b0;
        step(3);
        checks++; if ({cpu_ack, dram_addr} !== 9'h0) begin errors++; $display("FAIL rm_held got %h exp 0", {cpu_ack, dram_addr}); end
        rst = 1'b0;
        cpu_req = 1'b1; cpu_addr = 14'h02A5;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 20) begin
            step(1); cyc++;
            if (cpu_ack) got = 1'b1;
        end
        checks++; if (cyc != 5) begin errors++; $display("FAIL rm_latency got %0d exp 5", cyc); end
        checks++; if (cpu_dout !== 4'hC) begin errors++; $display("FAIL rm_dout got %h exp c", cpu_dout); end
        cpu_req = 1'b0;
        step(3);
    endtask

`ifdef CHARRAM_REFRESH_EN
    task automatic test_refresh();
        int bad_strobes;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        bad_strobes = 0;
        for (int s = 0; s < 257; s++) begin
            for (int p = 1; p <= 8; p++) begin
                step(1);
                if (!cas_n || !wr_n || !rd_n) bad_strobes++;
                if (p == 1) begin
                    checks++; if ({ras_n, dram_addr} !== {1'b0, 8'(s)}) begin errors++; $display("FAIL ref_row slot %0d got %h exp %h", s, {ras_n, dram_addr}, {1'b0, 8'(s)}); end
                end
            end
        end
        checks++; if (bad_strobes != 0) begin errors++; $display("FAIL ref_cas got %0d exp 0", bad_strobes); end
    endtask
`else
    task automatic test_idle();
        int low;
        align();
        low = 0;
        for (int p = 1; p <= 8; p++) begin
            step(1);
            if ({ras_n, cas_n, wr_n, rd_n} !== 4'hF) low++;
        end
        checks++; if (low != 0) begin errors++; $display("FAIL idle_strobes got %0d exp 0", low); end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_contention();
        test_back_to_back();
        test_sync_abort();
        test_reset_mid();
`ifdef CHARRAM_REFRESH_EN
        test_refresh();
`else
        test_idle();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
